pulse_scheduler: RTL

- Sits directly downstream of the core's decode stage and consumes the quantum pulse descriptors issued there.
- Each descriptor carries a delay and a pulse-memory address; the block buffers them in an in-order FIFO.
- It holds off each descriptor for its delay in clock cycles, then presents the pulse address to the pulse generator over a valid/ready handshake.
- Single clock domain; it also provides back-pressure and status to the core.

---
 rtl/pulse_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pulse_scheduler.sv
// rtl/pulse_scheduler.sv - in-order pulse descriptor FIFO with per-entry delay and valid/ready issue
module pulse_scheduler #(
    parameter int DEPTH   = 8,
    parameter int DELAY_W = 16,
    parameter int ADDR_W  = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     desc_valid,
    input  logic [DELAY_W-1:0]       desc_delay,
    input  logic [ADDR_W-1:0]        desc_addr,
    output logic                     desc_ready,
    output logic                     pulse_valid,
    output logic [ADDR_W-1:0]        pulse_addr,
    input  logic                     pulse_ready,
    input  logic                     abort,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DELAY_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE
    } state_t;

    logic [EW-1:0]      mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [DELAY_W-1:0] timer;
    state_t             state;

    logic               push;
    logic               pop;
    logic [DELAY_W-1:0] head_delay;
    logic [ADDR_W-1:0]  head_addr;

    assign desc_ready = !abort && (count < CW'(DEPTH));
    assign push       = desc_valid && desc_ready;
    assign busy       = (state != IDLE) || (count != '0);
    assign head_delay = mem[rd_ptr][EW-1:ADDR_W];
    assign head_addr  = mem[rd_ptr][ADDR_W-1:0];

    // count is registered, so an entry pushed this cycle cannot be popped until the next
    always_comb begin
        pop = 1'b0;
        if (!abort && count != '0) begin
            if (state == IDLE)
                pop = 1'b1;
            else if (state == ISSUE && pulse_ready)
                pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {desc_delay, desc_addr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= IDLE;
            timer       <= '0;
            pulse_valid <= 1'b0;
            pulse_addr  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (desc_valid && !desc_ready && !abort)
                overflow <= 1'b1;

            if (abort) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                state       <= IDLE;
                pulse_valid <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;

                if (push && !pop)
                    count <= count + 1'b1;
                else if (!push && pop)
                    count <= count - 1'b1;

                if (pop) begin
                    pulse_addr <= head_addr;
                    timer      <= head_delay;
                    if (head_delay != '0) begin
                        state       <= WAIT;
                        pulse_valid <= 1'b0;
                    end else begin
                        state       <= ISSUE;
                        pulse_valid <= 1'b1;
                    end
                end else begin
                    case (state)
                        WAIT: begin
                            timer <= timer - 1'b1;
                            if (timer == DELAY_W'(1)) begin
                                state       <= ISSUE;
                                pulse_valid <= 1'b1;
                            end
                        end
                        ISSUE: begin
                            if (pulse_ready) begin
                                state       <= IDLE;
                                pulse_valid <= 1'b0;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
